// File: rtl/gshare_counter_table.sv
// gshare pattern history table: 2-bit saturating counters indexed by PC ^ GHR.
// Predicts the DEC branch, carries its index to EX, and trains on ALU resolution.
module gshare_counter_table #(
   parameter int BPRED_WIDTH = 8
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_DEC_Is_Branch,
   input  logic [31:0]            i_DEC_PC,
   input  logic [BPRED_WIDTH-1:0] i_Global_History,
   input  logic                   i_Stall,
   input  logic                   i_Flush,
   input  logic                   i_ALU_Branch_Valid,
   input  logic                   i_ALU_Branch_Outcome,
   output logic                   o_Prediction,
   output logic                   o_Mispredict,
   output logic                   o_Init_Done
);

   localparam int DEPTH = 2 ** BPRED_WIDTH;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                 state_reg, state_next;
   logic [BPRED_WIDTH-1:0] init_idx_reg, init_idx_next;
   logic                   ex_valid_reg, ex_valid_next;
   logic [BPRED_WIDTH-1:0] ex_idx_reg, ex_idx_next;
   logic                   ex_pred_reg, ex_pred_next;

   logic [1:0]             pht_mem [DEPTH];

   logic                   run;
   logic                   train;
   logic [BPRED_WIDTH-1:0] idx_rd;
   logic [1:0]             cnt_rd;
   logic [1:0]             cnt_ex;
   logic [1:0]             cnt_upd;
   logic                   wr_en;
   logic [BPRED_WIDTH-1:0] wr_idx;
   logic [1:0]             wr_data;
   logic                   unused_pc_bits;

   assign unused_pc_bits = ^{i_DEC_PC[31:BPRED_WIDTH+2], i_DEC_PC[1:0]};

   assign run    = (state_reg == ST_RUN);
   assign train  = run & i_ALU_Branch_Valid & ex_valid_reg;
   assign idx_rd = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History;
   assign cnt_rd = pht_mem[idx_rd];
   assign cnt_ex = pht_mem[ex_idx_reg];

   always_comb begin
      cnt_upd = cnt_ex;
      if (i_ALU_Branch_Outcome) begin
         if (cnt_ex != 2'b11) cnt_upd = cnt_ex + 2'd1;
      end else begin
         if (cnt_ex != 2'b00) cnt_upd = cnt_ex - 2'd1;
      end
   end

   // Single write port shared by the init sweep (weak-taken fill) and training.
   assign wr_en   = !run | train;
   assign wr_idx  = run ? ex_idx_reg : init_idx_reg;
   assign wr_data = run ? cnt_upd : 2'b10;

   always_ff @(posedge i_Clk) begin
      if (wr_en) pht_mem[wr_idx] <= wr_data;
   end

   always_comb begin
      o_Prediction = 1'b1;
      if (run) begin
         // Write-first: a same-cycle training write to the read index wins.
         if (train && (ex_idx_reg == idx_rd)) o_Prediction = cnt_upd[1];
         else                                 o_Prediction = cnt_rd[1];
      end
      o_Mispredict = train & (i_ALU_Branch_Outcome != ex_pred_reg);
      o_Init_Done  = run;
   end

   always_comb begin
      state_next    = state_reg;
      init_idx_next = init_idx_reg;
      if (state_reg == ST_INIT) begin
         init_idx_next = init_idx_reg + BPRED_WIDTH'(1);
         if (init_idx_reg == {BPRED_WIDTH{1'b1}}) state_next = ST_RUN;
      end
   end

   always_comb begin
      ex_valid_next = ex_valid_reg;
      ex_idx_next   = ex_idx_reg;
      ex_pred_next  = ex_pred_reg;
      if (!run) begin
         ex_valid_next = 1'b0;
      end else if (i_Flush) begin
         ex_valid_next = 1'b0;
      end else if (i_DEC_Is_Branch && !i_Stall) begin
         ex_valid_next = 1'b1;
         ex_idx_next   = idx_rd;
         ex_pred_next  = o_Prediction;
      end else if (i_ALU_Branch_Valid && ex_valid_reg) begin
         ex_valid_next = 1'b0;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_reg    <= ST_INIT;
         init_idx_reg <= '0;
         ex_valid_reg <= 1'b0;
         ex_idx_reg   <= '0;
         ex_pred_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         init_idx_reg <= init_idx_next;
         ex_valid_reg <= ex_valid_next;
         ex_idx_reg   <= ex_idx_next;
         ex_pred_reg  <= ex_pred_next;
      end
   end

endmodule

// File: doc/gshare_counter_table.md
# gshare_counter_table

Pattern history table for the gshare branch predictor. It forms an index from the global history XOR'd with low PC bits, and returns a taken/not-taken prediction for the branch in DEC. It carries that index to EX and trains the 2-bit saturating counter at that index when the ALU resolves the branch. The block sits between the global history register, whose output it consumes and whose `i_Prediction` it drives, and the fetch/PC-select logic.

## Interface
- `BPRED_WIDTH`, default 8: index width; table has 2^BPRED_WIDTH 2-bit counters.
- `i_Clk`  in  1: clock.
- `i_Reset`  in  1: asynchronous, active-high reset.
- `i_DEC_Is_Branch`  in  1: branch in DEC stage this cycle.
- `i_DEC_PC`  in  32: PC of the DEC instruction; bits [BPRED_WIDTH+1:2] are used.
- `i_Global_History`  in  BPRED_WIDTH: current GHR contents.
- `i_Stall`  in  1: pipeline stall; DEC-to-EX capture is suppressed.
- `i_Flush`  in  1: kill the pending EX branch record.
- `i_ALU_Branch_Valid`  in  1: branch resolved in EX this cycle.
- `i_ALU_Branch_Outcome`  in  1: 1 = taken.
- `o_Prediction`  out  1: prediction for the DEC branch (combinational).
- `o_Mispredict`  out  1: EX resolution disagrees with the stored prediction (combinational).
- `o_Init_Done`  out  1: table initialisation complete.

## Operation
- Read index: `idx_rd = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History`.
- Counter encoding:
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction = counter MSB.
- Saturating update:
  - Taken increments, saturating at 11.
  - Not-taken decrements, saturating at 00.
- State machine, two states:
  - INIT (reset state):
    - A sweep counter `init_idx` starts at 0 and writes 2'b10 to entry `init_idx` each cycle, then increments.
    - On the cycle it writes entry 2^BPRED_WIDTH-1, the next state is RUN.
    - In INIT: `o_Prediction`=1, `o_Mispredict`=0, `o_Init_Done`=0, ALU updates are dropped, EX record is held invalid.
  - RUN:
    - `o_Init_Done`=1.
    - Normal predict/train.
    - Stays in RUN until reset.
- EX record registers: `ex_valid`, `ex_idx[BPRED_WIDTH-1:0]`, `ex_pred`. Priority at each clock edge:
  1. `i_Flush` sets `ex_valid`<=0.
  2. Otherwise, if `i_DEC_Is_Branch` & !`i_Stall`: `ex_valid`<=1, `ex_idx`<=`idx_rd`, `ex_pred`<=`o_Prediction`.
  3. Otherwise, if `i_ALU_Branch_Valid` & `ex_valid`: `ex_valid`<=0 (record consumed).
  4. Otherwise: hold.
- Training: when `i_ALU_Branch_Valid` & `ex_valid` in RUN, `table[ex_idx]` is updated with `i_ALU_Branch_Outcome` at the clock edge. This happens even if `i_Flush` is asserted the same cycle, because the resolving branch is older than the flush.
- `i_ALU_Branch_Valid` with `ex_valid`=0: no update, `o_Mispredict`=0.
- `o_Mispredict` = `i_ALU_Branch_Valid` & `ex_valid` & (`i_ALU_Branch_Outcome` != `ex_pred`) & RUN.
- Write-first bypass: if a training write targets `idx_rd` in the same cycle, `o_Prediction` uses the post-update counter MSB.

## Timing
- Reset asserted:
  - State INIT, `init_idx`=0.
  - `ex_valid`=0, `ex_idx`=0, `ex_pred`=0.
  - `o_Prediction`=1, `o_Mispredict`=0, `o_Init_Done`=0.
  - Table contents are undefined until swept.
- Init latency: `o_Init_Done` rises 2^BPRED_WIDTH cycles after the first clock edge with reset deasserted (256 cycles at default).
- Reset asserted mid-sweep or in RUN: immediately returns to INIT with `init_idx`=0. The full sweep repeats.
- `o_Prediction`: zero-cycle combinational from `i_DEC_PC` / `i_Global_History`. The GHR samples it at the same edge.
- Counter write: visible to the read port in the same cycle via bypass, and from the table on the following cycle.
- Back-to-back branches: DEC capture and EX resolve in the same cycle is legal. The record is replaced by the new branch (priority 2), and the old index is trained.
- Stalled DEC branch: no capture. The record stays until it is resolved or flushed.

## Test plan
1. Reset, BPRED_WIDTH=4:
   - `o_Init_Done`=0 for 16 cycles, then 1.
   - Every index then predicts 1.
   - `o_Prediction`=1 throughout INIT.
2. Train not-taken:
   - PC=0x0000_0014, GHR=4'b0011, so idx=5^3=6.
   - Resolve not-taken twice: counter goes 10→01→00.
   - `o_Mispredict`=1 on the first resolve and 0 on the second.
   - Later reads of idx 6 predict 0.
   - Two taken resolves then return it to 10.
3. Saturation:
   - Four taken resolves on idx 2: counter stays at 11.
   - One not-taken resolve: counter becomes 10, prediction still 1.
4. Bypass:
   - Idx 6 is at 01. It resolves taken in the same cycle a DEC branch also maps to idx 6.
   - `o_Prediction`=1 that cycle, and `ex_pred`=1 is captured.
5. Flush/stall:
   - Flush with no ALU valid: the following `i_ALU_Branch_Valid` causes no table change and `o_Mispredict`=0.
   - DEC branch with `i_Stall`=1: not captured.
   - Flush coinciding with a resolve: the resolve still trains the counter.
6. Reset mid-sweep:
   - Assert `i_Reset` at init cycle 7.
   - After release, `o_Init_Done` rises only after 16 more cycles.
   - ALU updates during INIT are ignored.
